// File: rtl/benes_pkg.sv
// benes_pkg: shared constants, types and wiring tables for the 8-port
// Benes network and its route controller (used with BENES_PERM_CHECK_EN).
package benes_pkg;

  localparam int N_PORTS      = 8;
  localparam int N_STAGES     = 5;
  localparam int SW_PER_STAGE = 4;

  typedef logic [2:0] port_idx_t;
  typedef logic [3:0] stage_cfg_t;

  // Output line of stage s -> input line of stage s+1.
  localparam port_idx_t T01 [N_PORTS] =
    '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2, 3'd6, 3'd3, 3'd7};
  localparam port_idx_t T12 [N_PORTS] =
    '{3'd0, 3'd2, 3'd1, 3'd3, 3'd4, 3'd6, 3'd5, 3'd7};
  localparam port_idx_t T23 [N_PORTS] =
    '{3'd0, 3'd2, 3'd1, 3'd3, 3'd4, 3'd6, 3'd5, 3'd7};
  localparam port_idx_t T34 [N_PORTS] =
    '{3'd0, 3'd2, 3'd4, 3'd6, 3'd1, 3'd3, 3'd5, 3'd7};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_OUTER,
    ST_INNER,
    ST_MID,
    ST_DONE
  } state_e;

endpackage

// File: rtl/benes_route_ctrl_loop_step.sv
// benes_loop_step: one combinational looping step over a 4- or 8-port
// level; resolves one input switch and its partner output switch.
module benes_loop_step #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0][W-1:0] perm_i,
  input  logic [N/2-1:0]      done_i,
  input  logic                cont_i,
  input  logic [W-2:0]        cont_sw_i,
  input  logic                cont_x_i,
  output logic                en_o,
  output logic [W-2:0]        in_sw_o,
  output logic                in_x_o,
  output logic [W-2:0]        out_sw_o,
  output logic                out_x_o,
  output logic                nxt_o,
  output logic [W-2:0]        nxt_sw_o,
  output logic                nxt_x_o
);

  localparam int NS = N / 2;

  logic [W-2:0] c;
  logic         x;
  logic [W-1:0] u;
  logic [W-1:0] d;
  logic [W-1:0] t;
  logic [W-1:0] j;
  logic [NS-1:0] dn;

  // Follow the open loop, or start a new one at the lowest free switch.
  always_comb begin
    c    = '0;
    x    = 1'b0;
    en_o = 1'b0;
    if (cont_i) begin
      c    = cont_sw_i;
      x    = cont_x_i;
      en_o = 1'b1;
    end else begin
      for (int k = NS - 1; k >= 0; k--) begin
        if (!done_i[k]) begin
          c    = (W-1)'(k);
          en_o = 1'b1;
        end
      end
    end
    u = {c, x};
    d = perm_i[u];
    t = {d[W-1:1], ~d[0]};
    j = '0;
    for (int k = 0; k < N; k++) begin
      if (perm_i[k] == t) j = W'(k);
    end
    dn       = done_i;
    dn[c]    = 1'b1;
    in_sw_o  = c;
    in_x_o   = x;
    out_sw_o = d[W-1:1];
    out_x_o  = d[0];
    nxt_sw_o = j[W-1:1];
    nxt_x_o  = ~j[0];
    nxt_o    = en_o && !dn[j[W-1:1]];
  end

endmodule

// File: rtl/benes_route_ctrl.sv
// benes_route_ctrl: looping-algorithm switch setter for the 8-port Benes
// network. Optional bijection check: define BENES_PERM_CHECK_EN.
module benes_route_ctrl
  import benes_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         perm_valid,
  output logic                         perm_ready,
  input  port_idx_t [N_PORTS-1:0]      perm,
  output logic                         cfg_valid,
  input  logic                         cfg_ready,
  output stage_cfg_t [N_STAGES-1:0]    switch_set,
  output logic                         cfg_err
);

  state_e state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic rdy_q, rdy_d;
  logic vld_q, vld_d;
  logic accept;

  port_idx_t [N_PORTS-1:0] perm_q;
  logic dup_q, dup_c;
  stage_cfg_t s0_q, s1_q, s3_q, s4_q, s2_c;
  logic [3:0] odone_q;
  logic ocont_q, ocx_q;
  logic [1:0] ocsw_q;
  logic [1:0][1:0] idone_q;
  logic [1:0] icont_q, icsw_q, icx_q;
  stage_cfg_t [N_STAGES-1:0] sw_q;
  logic err_q;

  logic o_en, o_in_x, o_out_x, o_nxt, o_nxt_x;
  logic [1:0] o_in_sw, o_out_sw, o_nxt_sw;
  logic [1:0] i_en, i_in_x, i_out_x, i_nxt, i_nxt_x;
  logic [1:0] i_in_sw, i_out_sw, i_nxt_sw;
  logic [1:0][1:0] s1_idx, s3_idx;

  logic [1:0][3:0][1:0] sp;
  port_idx_t oi, src, dst, lin;

  assign accept     = perm_valid && rdy_q;
  assign perm_ready = rdy_q;
  assign cfg_valid  = vld_q;
  assign switch_set = sw_q;
  assign cfg_err    = err_q;

`ifdef BENES_PERM_CHECK_EN
  // Any repeated destination means the request is not a bijection.
  always_comb begin
    dup_c = 1'b0;
    for (int a = 0; a < N_PORTS; a++) begin
      for (int b = a + 1; b < N_PORTS; b++) begin
        if (perm_q[a] == perm_q[b]) dup_c = 1'b1;
      end
    end
  end
`else
  assign dup_c = 1'b0;
`endif

  // State, counter and handshake flag registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
      vld_q   <= vld_d;
    end
  end

  // Next state: fixed-length phases keep latency data independent.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        state_d = ST_OUTER;
        cnt_d   = '0;
      end
      ST_OUTER: begin
        if (dup_q) begin
          state_d = ST_DONE;
        end else if (cnt_q == 2'd3) begin
          state_d = ST_INNER;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      ST_INNER: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd1) state_d = ST_MID;
      end
      ST_MID: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (cfg_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    rdy_d = (state_d == ST_IDLE);
    vld_d = (state_d == ST_DONE);
  end

  benes_loop_step #(.N(8), .W(3)) u_outer (
    .perm_i    (perm_q),
    .done_i    (odone_q),
    .cont_i    (ocont_q),
    .cont_sw_i (ocsw_q),
    .cont_x_i  (ocx_q),
    .en_o      (o_en),
    .in_sw_o   (o_in_sw),
    .in_x_o    (o_in_x),
    .out_sw_o  (o_out_sw),
    .out_x_o   (o_out_x),
    .nxt_o     (o_nxt),
    .nxt_sw_o  (o_nxt_sw),
    .nxt_x_o   (o_nxt_x)
  );

  // Local permutation seen by each 4x4 subnet once stage 0 is fixed.
  always_comb begin
    sp  = '0;
    oi  = '0;
    src = '0;
    dst = '0;
    lin = '0;
    for (int o = 0; o < N_PORTS; o++) begin
      oi  = port_idx_t'(o);
      src = {oi[2:1], oi[0] ^ s0_q[oi[2:1]]};
      dst = perm_q[src];
      lin = T01[oi];
      sp[lin[2]][lin[1:0]] = dst[2:1];
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_sub
    benes_loop_step #(.N(4), .W(2)) u_inner (
      .perm_i    (sp[g]),
      .done_i    (idone_q[g]),
      .cont_i    (icont_q[g]),
      .cont_sw_i (icsw_q[g]),
      .cont_x_i  (icx_q[g]),
      .en_o      (i_en[g]),
      .in_sw_o   (i_in_sw[g]),
      .in_x_o    (i_in_x[g]),
      .out_sw_o  (i_out_sw[g]),
      .out_x_o   (i_out_x[g]),
      .nxt_o     (i_nxt[g]),
      .nxt_sw_o  (i_nxt_sw[g]),
      .nxt_x_o   (i_nxt_x[g])
    );
    assign s1_idx[g] = {1'(g), i_in_sw[g]};
    assign s3_idx[g] = {1'(g), i_out_sw[g]};
    // Centre 2x2s: send each upper/lower stage-1 output to its row.
    assign s2_c[2*g]   = sp[g][{1'b0, s1_q[2*g]}][1];
    assign s2_c[2*g+1] = sp[g][{1'b0, ~s1_q[2*g]}][1];
  end

  // Working settings; the visible word only moves on entry to DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perm_q  <= '0;
      dup_q   <= 1'b0;
      s0_q    <= '0;
      s1_q    <= '0;
      s3_q    <= '0;
      s4_q    <= '0;
      odone_q <= '0;
      ocont_q <= 1'b0;
      ocsw_q  <= '0;
      ocx_q   <= 1'b0;
      idone_q <= '0;
      icont_q <= '0;
      icsw_q  <= '0;
      icx_q   <= '0;
      sw_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && accept) begin
        perm_q  <= perm;
        dup_q   <= 1'b0;
        s0_q    <= '0;
        s1_q    <= '0;
        s3_q    <= '0;
        s4_q    <= '0;
        odone_q <= '0;
        ocont_q <= 1'b0;
        idone_q <= '0;
        icont_q <= '0;
      end
      if (state_q == ST_CHECK) dup_q <= dup_c;
      if (state_q == ST_OUTER && !dup_q && o_en) begin
        s0_q[o_in_sw]    <= o_in_x;
        s4_q[o_out_sw]   <= o_out_x;
        odone_q[o_in_sw] <= 1'b1;
        ocont_q          <= o_nxt;
        ocsw_q           <= o_nxt_sw;
        ocx_q            <= o_nxt_x;
      end
      if (state_q == ST_OUTER && dup_q) begin
        sw_q  <= '0;
        err_q <= 1'b1;
      end
      if (state_q == ST_INNER) begin
        for (int g = 0; g < 2; g++) begin
          if (i_en[g]) begin
            s1_q[s1_idx[g]]        <= i_in_x[g];
            s3_q[s3_idx[g]]        <= i_out_x[g];
            idone_q[g][i_in_sw[g]] <= 1'b1;
            icont_q[g]             <= i_nxt[g];
            icsw_q[g]              <= i_nxt_sw[g];
            icx_q[g]               <= i_nxt_x[g];
          end
        end
      end
      if (state_q == ST_MID) begin
        sw_q[0] <= s0_q;
        sw_q[1] <= s1_q;
        sw_q[2] <= s2_c;
        sw_q[3] <= s3_q;
        sw_q[4] <= s4_q;
        err_q   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_benes_route_ctrl.sv
// tb_benes_route_ctrl: directed vectors, random bijections through a
// reference network, stall, error and mid-run reset sequences.
module tb_benes_route_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic perm_valid;
  logic perm_ready;
  logic [7:0][2:0] perm;
  logic cfg_valid;
  logic cfg_ready;
  logic [4:0][3:0] switch_set;
  logic cfg_err;

  int n_chk  = 0;
  int n_pass = 0;

  benes_route_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .perm_valid (perm_valid),
    .perm_ready (perm_ready),
    .perm       (perm),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .switch_set (switch_set),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0][2:0] p;
    logic [4:0][3:0] sw;
  } vec_t;

  vec_t vt [4];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  // Independent model of the 5-stage network wiring.
  function automatic int route(input logic [4:0][3:0] sw, input int i);
    int l;
    int lc;
    l = i;
    if (sw[0][l/2]) l = l ^ 1;
    l = (l % 2 == 1) ? 4 + l / 2 : l / 2;
    for (int s = 1; s <= 2; s++) begin
      if (sw[s][l/2]) l = l ^ 1;
      lc = l % 4;
      lc = (lc % 2 == 1) ? 2 + lc / 2 : lc / 2;
      l = (l / 4) * 4 + lc;
    end
    if (sw[3][l/2]) l = l ^ 1;
    l = (l < 4) ? 2 * l : 2 * (l - 4) + 1;
    if (sw[4][l/2]) l = l ^ 1;
    return l;
  endfunction

  function automatic int misroutes(input logic [4:0][3:0] sw,
                                   input logic [7:0][2:0] p);
    int bad;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (route(sw, i) != int'(p[i])) bad++;
    end
    return bad;
  endfunction

  task automatic send(input logic [7:0][2:0] p);
    int w;
    w = 0;
    while (!perm_ready && w < 40) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk("send_ready", {31'd0, perm_ready}, 32'd1);
    perm       = p;
    perm_valid = 1'b1;
    @(posedge clk);
    #1;
    perm_valid = 1'b0;
  endtask

  task automatic wait_cfg(output int lat);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (cfg_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic ack();
    cfg_ready = 1'b1;
    @(posedge clk);
    #1;
    cfg_ready = 1'b0;
    chk("ready_after_ack", {31'd0, perm_ready}, 32'd1);
  endtask

  task automatic run(input logic [7:0][2:0] p, output int lat,
                     output logic [4:0][3:0] sw, output logic err);
    send(p);
    wait_cfg(lat);
    sw  = switch_set;
    err = cfg_err;
    ack();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    logic [4:0][3:0] sw;
    logic [4:0][3:0] rot_sw;
    logic err;
    logic [7:0][2:0] p;
    logic [7:0][2:0] zero_p;
    logic [2:0] tmp;

    vt[0].p  = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    vt[0].sw = {4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    vt[1].p  = {3'd6, 3'd7, 3'd4, 3'd5, 3'd2, 3'd3, 3'd0, 3'd1};
    vt[1].sw = {4'hF, 4'h0, 4'h0, 4'h0, 4'h0};
    vt[2].p  = {3'd3, 3'd2, 3'd1, 3'd0, 3'd7, 3'd6, 3'd5, 3'd4};
    vt[2].sw = {4'h0, 4'h0, 4'hF, 4'h0, 4'h0};
    vt[3].p  = {3'd0, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1};
    vt[3].sw = {4'hF, 4'hC, 4'h8, 4'h0, 4'h0};
    zero_p   = '0;

    rst_n      = 1'b0;
    perm_valid = 1'b0;
    cfg_ready  = 1'b0;
    perm       = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_perm_ready", {31'd0, perm_ready}, 32'd0);
    chk("rst_cfg_valid", {31'd0, cfg_valid}, 32'd0);
    chk("rst_cfg_err", {31'd0, cfg_err}, 32'd0);
    chk("rst_switch_set", {12'd0, switch_set}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_rst", {31'd0, perm_ready}, 32'd1);

    for (int v = 0; v < 4; v++) begin
      run(vt[v].p, lat, sw, err);
      chk($sformatf("vec%0d_latency", v), lat, 32'd8);
      chk($sformatf("vec%0d_switch_set", v), {12'd0, sw},
          {12'd0, vt[v].sw});
      chk($sformatf("vec%0d_err", v), {31'd0, err}, 32'd0);
      chk($sformatf("vec%0d_route", v), misroutes(sw, vt[v].p), 32'd0);
    end

    for (int it = 0; it < 200; it++) begin
      for (int i = 0; i < 8; i++) p[i] = 3'(i);
      for (int i = 7; i > 0; i--) begin
        int r;
        r    = int'($urandom_range(i, 0));
        tmp  = p[i];
        p[i] = p[r];
        p[r] = tmp;
      end
      run(p, lat, sw, err);
      chk($sformatf("rand%0d_latency", it), lat, 32'd8);
      chk($sformatf("rand%0d_route", it), misroutes(sw, p), 32'd0);
    end

    run(zero_p, lat, sw, err);
`ifdef BENES_PERM_CHECK_EN
    chk("dup_latency", lat, 32'd2);
    chk("dup_err", {31'd0, err}, 32'd1);
    chk("dup_switch_set", {12'd0, sw}, 32'd0);
`else
    chk("dup_latency", lat, 32'd8);
    chk("dup_err", {31'd0, err}, 32'd0);
`endif

    send(vt[3].p);
    wait_cfg(lat);
    chk("stall_latency", lat, 32'd8);
    rot_sw = vt[3].sw;
    for (int c = 0; c < 5; c++) begin
      perm       = vt[0].p;
      perm_valid = (c % 2 == 0);
      @(posedge clk);
      #1;
      chk($sformatf("stall%0d_valid", c), {31'd0, cfg_valid}, 32'd1);
      chk($sformatf("stall%0d_sw", c), {12'd0, switch_set},
          {12'd0, rot_sw});
      chk($sformatf("stall%0d_ready", c), {31'd0, perm_ready}, 32'd0);
    end
    perm_valid = 1'b0;
    ack();
    chk("post_ack_valid", {31'd0, cfg_valid}, 32'd0);
    @(posedge clk);
    #1;
    chk("no_ghost_req", {31'd0, perm_ready}, 32'd1);

    send(vt[3].p);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_perm_ready", {31'd0, perm_ready}, 32'd0);
    chk("midrst_cfg_valid", {31'd0, cfg_valid}, 32'd0);
    chk("midrst_cfg_err", {31'd0, cfg_err}, 32'd0);
    chk("midrst_switch_set", {12'd0, switch_set}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_ready_back", {31'd0, perm_ready}, 32'd1);
    run(vt[0].p, lat, sw, err);
    chk("after_rst_latency", lat, 32'd8);
    chk("after_rst_sw", {12'd0, sw}, 32'd0);
    chk("after_rst_err", {31'd0, err}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
